// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t : controller state encoding. Code 2'd3 is unused; the
//             controller treats it as illegal and returns to ST_IDLE.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, purely combinational.
// Ports:
//   a, b, c : addend bits and carry-in
//   sum     : a ^ b ^ c
//   carry   : majority(a, b, c)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: adds two WIDTH-bit operands plus a carry-in, one bit
// per clock, LSB first, using a single full_adder cell.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request a new addition (ignored while busy)
//   a, b  : operands, captured when start is accepted
//   cin   : carry-in, captured when start is accepted
//   busy  : high while bits are being processed
//   done  : one-cycle pulse, sum/cout valid
//   sum   : registered result bits [WIDTH-1:0]
//   cout  : registered result bit WIDTH
// Handshake: start is a level sampled at each rising edge; it is accepted
// only in ST_IDLE or ST_DONE. A result is reported by exactly one done
// cycle; there is no backpressure.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry;

  logic load, step, finish;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c    (carry),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  // New sum bit enters at the MSB; after WIDTH steps bit 0 has reached the LSB.
  assign s_next = {fa_sum, s_sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Accepting here gives back-to-back operation with no idle gap.
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      s_sr  <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      s_sr  <= s_next;
      carry <= fa_carry;
      // Hold at the last bit index instead of wrapping past WIDTH-1.
      cnt   <= finish ? cnt : cnt + CW'(1);
    end
  end

  // Results change only on the step that completes an operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (finish) begin
      sum  <= s_next;
      cout <= fa_carry;
    end
  end

endmodule
